// File: rtl/fp_issue_ctrl.sv
// Floating-point issue controller: decodes F-type, LWC1 and SWC1 from the decode
// stage, holds a per-register result scoreboard, a write-back-port reservation
// vector and a divider-busy counter, and produces the FP register-file
// write-back strobe.
module fp_issue_ctrl #(
  parameter int NFPREG        = 32,
  parameter int LAT_ADD       = 2,
  parameter int LAT_MUL       = 4,
  parameter int LAT_DIV       = 12,
  parameter int LAT_LD        = 1,
  parameter int DIV_PIPELINED = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      id_valid,
  input  logic [5:0]                op,
  input  logic [5:0]                funct,
  input  logic [$clog2(NFPREG)-1:0] fs,
  input  logic [$clog2(NFPREG)-1:0] ft,
  input  logic [$clog2(NFPREG)-1:0] fd,
  input  logic                      ex_stall,
  input  logic                      flush,
  output logic                      issue,
  output logic                      stall,
  output logic                      illegal,
  output logic [3:0]                fpu_control,
  output logic [$clog2(NFPREG)-1:0] fp_dst,
  output logic                      wb_valid,
  output logic [$clog2(NFPREG)-1:0] wb_reg
);
  localparam int RW = $clog2(NFPREG);
  localparam int CW = $clog2(LAT_DIV + 1);
  localparam logic [5:0] OP_FP   = 6'b010001;
  localparam logic [5:0] OP_LWC1 = 6'b110001;
  localparam logic [5:0] OP_SWC1 = 6'b111001;

  // Decode results
  logic          fp_class, ill, rd_fs, rd_ft, wr, is_div;
  logic [CW-1:0] lat;
  logic [3:0]    ctrl;
  logic [RW-1:0] dst;

  // State: per-register countdown, reservation vector with tags, divider counter
  logic [CW-1:0] cnt_q [NFPREG];
  logic [CW-1:0] cnt_d [NFPREG];
  logic [LAT_DIV:1] res_q, res_d;
  logic [RW-1:0] tag_q [LAT_DIV:1];
  logic [RW-1:0] tag_d [LAT_DIV:1];
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_reg_q, wb_reg_d;

  logic [NFPREG-1:0] busy;
  logic [LAT_DIV:0]  res_ext;
  logic [CW-1:0]     slot;
  logic              raw, waw, wbc, div_haz;

  // Instruction decode: class, sources, destination, latency and FPU opcode
  always_comb begin
    fp_class = 1'b0;
    ill      = 1'b0;
    rd_fs    = 1'b0;
    rd_ft    = 1'b0;
    wr       = 1'b0;
    is_div   = 1'b0;
    lat      = '0;
    ctrl     = 4'b0000;
    dst      = '0;
    case (op)
      OP_FP: begin
        dst = fd;
        case (funct)
          6'b000000: begin fp_class = 1'b1; ctrl = 4'b0000; lat = CW'(LAT_ADD); rd_fs = 1'b1; rd_ft = 1'b1; wr = 1'b1; end
          6'b000001: begin fp_class = 1'b1; ctrl = 4'b0001; lat = CW'(LAT_ADD); rd_fs = 1'b1; rd_ft = 1'b1; wr = 1'b1; end
          6'b000010: begin fp_class = 1'b1; ctrl = 4'b0010; lat = CW'(LAT_MUL); rd_fs = 1'b1; rd_ft = 1'b1; wr = 1'b1; end
          6'b000011: begin fp_class = 1'b1; ctrl = 4'b0011; lat = CW'(LAT_DIV); rd_fs = 1'b1; rd_ft = 1'b1; wr = 1'b1; is_div = 1'b1; end
          6'b000101: begin fp_class = 1'b1; ctrl = 4'b0100; lat = CW'(LAT_ADD); rd_fs = 1'b1; wr = 1'b1; end
          6'b000111: begin fp_class = 1'b1; ctrl = 4'b0101; lat = CW'(LAT_ADD); rd_fs = 1'b1; wr = 1'b1; end
          default:   ill = 1'b1;
        endcase
      end
      OP_LWC1: begin
        fp_class = 1'b1;
        lat      = CW'(LAT_LD);
        wr       = 1'b1;
        dst      = ft;
      end
      OP_SWC1: begin
        fp_class = 1'b1;
        rd_ft    = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazard detection against the current scoreboard and issue/stall generation
  always_comb begin
    for (int r = 0; r < NFPREG; r++) busy[r] = (cnt_q[r] != '0);
    // Bit 0 is a dummy so a zero latency (non-writing op) indexes safely.
    res_ext = {res_q, 1'b0};
    raw     = (rd_fs && busy[fs]) || (rd_ft && busy[ft]);
    waw     = wr && busy[dst];
    wbc     = wr && res_ext[lat];
    div_haz = is_div && (DIV_PIPELINED == 0) && (div_cnt_q != '0);
    issue   = id_valid && fp_class && !ex_stall && !flush && !raw && !waw && !wbc && !div_haz;
    stall   = id_valid && fp_class && !issue && !flush;
    illegal = id_valid && ill;
  end

  assign fpu_control = ctrl;
  assign fp_dst      = dst;
  assign wb_valid    = wb_valid_q;
  assign wb_reg      = wb_reg_q;

  // Next state: age everything by one cycle, then merge the newly issued op
  always_comb begin
    for (int r = 0; r < NFPREG; r++) cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
    div_cnt_d = (div_cnt_q != '0) ? div_cnt_q - CW'(1) : '0;
    for (int k = 1; k < LAT_DIV; k++) begin
      res_d[k] = res_q[k+1];
      tag_d[k] = tag_q[k+1];
    end
    res_d[LAT_DIV] = 1'b0;
    tag_d[LAT_DIV] = '0;
    wb_valid_d     = res_q[1];
    wb_reg_d       = tag_q[1];
    slot           = lat - CW'(1);
    if (issue && wr) begin
      cnt_d[dst] = lat;
      // res[L] seen this cycle becomes res[L-1] after the edge; L=1 goes straight to the strobe.
      if (lat == CW'(1)) begin
        wb_valid_d = 1'b1;
        wb_reg_d   = dst;
      end else begin
        res_d[slot] = 1'b1;
        tag_d[slot] = dst;
      end
    end
    if (issue && is_div && (DIV_PIPELINED == 0)) div_cnt_d = CW'(LAT_DIV - 1);
  end

  // State registers; reset discards every in-flight write-back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NFPREG; r++) cnt_q[r] <= '0;
      for (int k = 1; k <= LAT_DIV; k++) tag_q[k] <= '0;
      res_q      <= '0;
      div_cnt_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
    end else begin
      for (int r = 0; r < NFPREG; r++) cnt_q[r] <= cnt_d[r];
      for (int k = 1; k <= LAT_DIV; k++) tag_q[k] <= tag_d[k];
      res_q      <= res_d;
      div_cnt_q  <= div_cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
    end
  end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: decode table on an empty scoreboard, then
// hand-timed multi-cycle hazard, divider, reset and write-back sequences.
module tb_fp_issue_ctrl;
  localparam logic [5:0] FP = 6'b010001, LW = 6'b110001, SW = 6'b111001;

  logic clk = 1'b0;
  logic reset_n;
  logic id_valid, ex_stall, flush;
  logic [5:0] op, funct;
  logic [4:0] fs, ft, fd;
  logic issue, stall, illegal, wb_valid;
  logic [3:0] fpu_control;
  logic [4:0] fp_dst, wb_reg;
  logic issue1, stall1, illegal1, wb_valid1;
  logic [3:0] fpu_control1;
  logic [4:0] fp_dst1, wb_reg1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_issue_ctrl #(.DIV_PIPELINED(0)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .op(op), .funct(funct),
    .fs(fs), .ft(ft), .fd(fd), .ex_stall(ex_stall), .flush(flush),
    .issue(issue), .stall(stall), .illegal(illegal), .fpu_control(fpu_control),
    .fp_dst(fp_dst), .wb_valid(wb_valid), .wb_reg(wb_reg));

  fp_issue_ctrl #(.DIV_PIPELINED(1)) dut_p (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .op(op), .funct(funct),
    .fs(fs), .ft(ft), .fd(fd), .ex_stall(ex_stall), .flush(flush),
    .issue(issue1), .stall(stall1), .illegal(illegal1), .fpu_control(fpu_control1),
    .fp_dst(fp_dst1), .wb_valid(wb_valid1), .wb_reg(wb_reg1));

  typedef struct {
    logic       v;
    logic [5:0] o, f;
    logic [4:0] s, t, d;
    logic       xs, fl;
    logic       e_issue, e_stall, e_ill;
    logic [3:0] e_ctrl;
    logic       chk_dst;
    logic [4:0] e_dst;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wb(input string name, input logic v, input logic [4:0] r,
                        input logic ev, input logic [4:0] er);
    chk({name, "_wbv"}, 32'(v), 32'(ev));
    if (ev) chk({name, "_wbr"}, 32'(r), 32'(er));
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    id_valid = v; op = o; funct = f; fs = s; ft = t; fd = d;
    ex_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released: cycle 0 starts.
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b1;
    idle();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    do_reset();
    @(negedge clk);
    chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("post_rst_issue_idle", 32'(issue), 32'd0);
    next_cycle();

    //           v  op  funct       fs  ft  fd xs fl iss stl ill ctrl    cd dst
    vecs[0]  = '{1, FP, 6'b000000, 1, 2, 3, 0, 0, 1, 0, 0, 4'b0000, 1, 3};
    vecs[1]  = '{1, FP, 6'b000001, 1, 2, 3, 0, 0, 1, 0, 0, 4'b0001, 1, 3};
    vecs[2]  = '{1, FP, 6'b000010, 1, 2, 4, 0, 0, 1, 0, 0, 4'b0010, 1, 4};
    vecs[3]  = '{1, FP, 6'b000011, 1, 2, 5, 0, 0, 1, 0, 0, 4'b0011, 1, 5};
    vecs[4]  = '{1, FP, 6'b000101, 1, 2, 6, 0, 0, 1, 0, 0, 4'b0100, 1, 6};
    vecs[5]  = '{1, FP, 6'b000111, 1, 2, 7, 0, 0, 1, 0, 0, 4'b0101, 1, 7};
    vecs[6]  = '{1, FP, 6'b001000, 1, 2, 7, 0, 0, 0, 0, 1, 4'b0000, 1, 7};
    vecs[7]  = '{1, LW, 6'b000010, 1, 9, 3, 0, 0, 1, 0, 0, 4'b0000, 1, 9};
    vecs[8]  = '{1, SW, 6'b000000, 1, 9, 3, 0, 0, 1, 0, 0, 4'b0000, 0, 0};
    vecs[9]  = '{1, FP, 6'b000000, 1, 2, 3, 1, 0, 0, 1, 0, 4'b0000, 1, 3};
    vecs[10] = '{1, FP, 6'b000000, 1, 2, 3, 0, 1, 0, 0, 0, 4'b0000, 1, 3};
    vecs[11] = '{1, 6'b000000, 6'b100000, 1, 2, 3, 0, 0, 0, 0, 0, 4'b0000, 0, 0};

    // Decode table; id_valid drops before each edge so the scoreboard stays empty.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].o, vecs[i].f, vecs[i].s, vecs[i].t, vecs[i].d);
      ex_stall = vecs[i].xs;
      flush = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_issue", i), 32'(issue), 32'(vecs[i].e_issue));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
      chk($sformatf("vec%0d_ctrl", i), 32'(fpu_control), 32'(vecs[i].e_ctrl));
      if (vecs[i].chk_dst) chk($sformatf("vec%0d_dst", i), 32'(fp_dst), 32'(vecs[i].e_dst));
      idle();
      next_cycle();
    end

    // RAW on an add result: f3 <- f2 + f0 waits for f2.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) drive(1, FP, 6'b000000, 5'd0, 5'd1, 5'd2);
      else if (c <= 3) drive(1, FP, 6'b000000, 5'd2, 5'd0, 5'd3);
      else idle();
      @(negedge clk);
      if (c <= 3) begin
        chk($sformatf("raw_c%0d_issue", c), 32'(issue), 32'(c == 0 || c == 3));
        chk($sformatf("raw_c%0d_stall", c), 32'(stall), 32'(c == 1 || c == 2));
      end
      chk_wb($sformatf("raw_c%0d", c), wb_valid, wb_reg, (c == 2 || c == 5), (c == 2) ? 5'd2 : 5'd3);
      next_cycle();
    end

    // Write-back port collision: mul presented at 8 would land on the divide's slot.
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c == 0) drive(1, FP, 6'b000011, 5'd0, 5'd1, 5'd4);
      else if (c == 8 || c == 9) drive(1, FP, 6'b000010, 5'd0, 5'd1, 5'd5);
      else idle();
      @(negedge clk);
      if (c == 0) chk("wbc_div_issue", 32'(issue), 32'd1);
      if (c == 8) begin
        chk("wbc_c8_stall", 32'(stall), 32'd1);
        chk("wbc_c8_issue", 32'(issue), 32'd0);
      end
      if (c == 9) chk("wbc_c9_issue", 32'(issue), 32'd1);
      chk_wb($sformatf("wbc_c%0d", c), wb_valid, wb_reg, (c == 12 || c == 13), (c == 12) ? 5'd4 : 5'd5);
      next_cycle();
    end

    // Back-to-back divides: blocking divider vs pipelined divider instance.
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      if (c == 0) drive(1, FP, 6'b000011, 5'd0, 5'd1, 5'd6);
      else if (c <= 12) drive(1, FP, 6'b000011, 5'd0, 5'd1, 5'd7);
      else idle();
      @(negedge clk);
      if (c <= 12) begin
        chk($sformatf("div_c%0d_issue", c), 32'(issue), 32'(c == 0 || c == 12));
        chk($sformatf("divp_c%0d_issue", c), 32'(issue1), 32'(c == 0 || c == 1));
      end
      if (c == 5) chk("div_c5_stall", 32'(stall), 32'd1);
      chk_wb($sformatf("div_c%0d", c), wb_valid, wb_reg, (c == 12 || c == 24), (c == 12) ? 5'd6 : 5'd7);
      chk_wb($sformatf("divp_c%0d", c), wb_valid1, wb_reg1, (c == 12 || c == 13), (c == 12) ? 5'd6 : 5'd7);
      next_cycle();
    end

    // Load-use: LWC1 f8, then neg f9 <- f8.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) drive(1, LW, 6'b000000, 5'd0, 5'd8, 5'd0);
      else if (c <= 2) drive(1, FP, 6'b000111, 5'd8, 5'd0, 5'd9);
      else idle();
      @(negedge clk);
      if (c == 0) begin
        chk("ld_issue", 32'(issue), 32'd1);
        chk("ld_dst", 32'(fp_dst), 32'd8);
      end
      if (c == 1) chk("neg_c1_stall", 32'(stall), 32'd1);
      if (c == 2) begin
        chk("neg_c2_issue", 32'(issue), 32'd1);
        chk("neg_c2_ctrl", 32'(fpu_control), 32'b0101);
      end
      chk_wb($sformatf("ld_c%0d", c), wb_valid, wb_reg, (c == 1 || c == 4), (c == 1) ? 5'd8 : 5'd9);
      next_cycle();
    end

    // Illegal funct held for several cycles never writes back.
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (c <= 2) drive(1, FP, 6'b000100, 5'd0, 5'd1, 5'd12);
      else idle();
      @(negedge clk);
      if (c <= 2) begin
        chk($sformatf("ill_c%0d_illegal", c), 32'(illegal), 32'd1);
        chk($sformatf("ill_c%0d_issue", c), 32'(issue), 32'd0);
        chk($sformatf("ill_c%0d_stall", c), 32'(stall), 32'd0);
      end
      chk_wb($sformatf("ill_c%0d", c), wb_valid, wb_reg, 1'b0, 5'd0);
      next_cycle();
    end

    // Reset while a multiply is in flight discards it and clears f10.
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) drive(1, FP, 6'b000010, 5'd0, 5'd1, 5'd10);
      else if (c == 4) drive(1, FP, 6'b000000, 5'd10, 5'd0, 5'd11);
      else idle();
      if (c == 2) reset_n = 1'b0;
      if (c == 4) reset_n = 1'b1;
      @(negedge clk);
      if (c == 0) chk("rstmul_issue", 32'(issue), 32'd1);
      if (c == 4) chk("rstadd_issue", 32'(issue), 32'd1);
      chk_wb($sformatf("rst_c%0d", c), wb_valid, wb_reg, (c == 6), 5'd11);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
